// File: rtl/iir_pkg.sv
// Shared types and helpers for the biquad scheduler.
// Frame FSM states, tap index, accumulator sizing, saturation.
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE,
    DONE
  } state_t;

  typedef logic [2:0] tap_t;

  localparam tap_t TAP_LAST = 3'd4;

  function automatic int acc_width(
    input int dw,
    input int cw
  );
    return dw + cw + 3;
  endfunction

  function automatic logic signed [31:0] sat(
    input logic signed [63:0] v,
    input int dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return 32'(hi);
    else if (v < lo) return 32'(lo);
    return 32'(v);
  endfunction

endpackage

// File: rtl/iir_biquad_scheduler_mac.sv
// Shared signed multiply-accumulate for the biquad engine.
// clr loads the product, sub negates it before accumulation.
module iir_mac_unit
  import iir_pkg::*;
#(
  parameter int COEFF_WIDTH = 18,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 37
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          sub,
  input  logic signed [COEFF_WIDTH-1:0] coef,
  input  logic signed [DATA_WIDTH-1:0]  opnd,
  output logic signed [ACC_WIDTH-1:0]   acc
);

  localparam int PW = COEFF_WIDTH + DATA_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_x;
  logic signed [ACC_WIDTH-1:0] base;

  assign prod   = coef * opnd;
  assign prod_x = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
  assign base   = clr ? '0 : acc;

  // accumulate one tap per enabled cycle
  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else if (en) acc <= sub ? base - prod_x : base + prod_x;
  end

endmodule

// File: rtl/iir_biquad_scheduler.sv
// Time-multiplexed direct-form-I biquad over NUM_CH channels.
// One MAC, per-channel history, coefficients latched per frame.
module iir_biquad_scheduler
  import iir_pkg::*;
#(
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_SCALE = 14,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_stb,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   din,
  input  logic [COEFF_WIDTH-1:0]         A2,
  input  logic [COEFF_WIDTH-1:0]         A3,
  input  logic [COEFF_WIDTH-1:0]         B1,
  input  logic [COEFF_WIDTH-1:0]         B2,
  input  logic [COEFF_WIDTH-1:0]         B3,
  output logic [NUM_CH*DATA_WIDTH-1:0]   dout,
  output logic                           dout_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int AW  = acc_width(DATA_WIDTH, COEFF_WIDTH);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CH - 1);

  typedef logic signed [DATA_WIDTH-1:0]  smp_t;
  typedef logic signed [COEFF_WIDTH-1:0] cof_t;

  state_t state, state_n;
  tap_t   tap;
  logic [CHW-1:0] ch;

  smp_t xin  [NUM_CH];
  smp_t x1   [NUM_CH];
  smp_t x2   [NUM_CH];
  smp_t y1   [NUM_CH];
  smp_t y2   [NUM_CH];
  smp_t pend [NUM_CH];

  cof_t b1_r, b2_r, b3_r, a2_r, a3_r;
  cof_t coef;
  smp_t opnd;
  logic sub;
  logic start;
  logic last_ch;

  logic signed [AW-1:0] acc;
  logic signed [63:0]   acc_sh;
  smp_t q;

  assign start   = sample_stb &&
                   (state == IDLE || state == DONE);
  assign last_ch = (ch == CH_LAST);
  assign acc_sh  = 64'(acc >>> COEFF_SCALE);
  assign q       = smp_t'(sat(acc_sh, DATA_WIDTH));

  // frame sequencing and status outputs
  always_comb begin
    state_n    = state;
    busy       = 1'b0;
    dout_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_stb) state_n = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (tap == TAP_LAST) state_n = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        state_n = last_ch ? DONE : MAC;
      end
      DONE: begin
        dout_valid = 1'b1;
        state_n    = sample_stb ? MAC : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // tap and channel counters, overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      tap     <= '0;
      ch      <= '0;
      overrun <= 1'b0;
    end else begin
      if (sample_stb && busy) overrun <= 1'b1;
      if (start) begin
        tap <= '0;
        ch  <= '0;
      end else if (state == MAC) begin
        tap <= (tap == TAP_LAST) ? '0 : tap + 3'd1;
      end else if (state == WRITE && !last_ch) begin
        ch <= ch + 1'b1;
      end
    end
  end

  // per-frame capture of inputs and coefficients
  always_ff @(posedge clk) begin
    if (reset) begin
      b1_r <= '0;
      b2_r <= '0;
      b3_r <= '0;
      a2_r <= '0;
      a3_r <= '0;
      for (int c = 0; c < NUM_CH; c++) xin[c] <= '0;
    end else if (start) begin
      b1_r <= B1;
      b2_r <= B2;
      b3_r <= B3;
      a2_r <= A2;
      a3_r <= A3;
      for (int c = 0; c < NUM_CH; c++)
        xin[c] <= din[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // channel history, pending results and output lanes
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        x1[c]   <= '0;
        x2[c]   <= '0;
        y1[c]   <= '0;
        y2[c]   <= '0;
        pend[c] <= '0;
      end
    end else if (state == WRITE) begin
      x2[ch]   <= x1[ch];
      x1[ch]   <= xin[ch];
      y2[ch]   <= y1[ch];
      y1[ch]   <= q;
      pend[ch] <= q;
      if (last_ch) begin
        for (int c = 0; c < NUM_CH; c++)
          dout[c*DATA_WIDTH +: DATA_WIDTH] <=
            (c == NUM_CH - 1) ? q : pend[c];
      end
    end
  end

  // tap operand selection
  always_comb begin
    coef = b1_r;
    opnd = xin[ch];
    sub  = 1'b0;
    unique case (tap)
      3'd0: begin
        coef = b1_r;
        opnd = xin[ch];
      end
      3'd1: begin
        coef = b2_r;
        opnd = x1[ch];
      end
      3'd2: begin
        coef = b3_r;
        opnd = x2[ch];
      end
      3'd3: begin
        coef = a2_r;
        opnd = y1[ch];
        sub  = 1'b1;
      end
      3'd4: begin
        coef = a3_r;
        opnd = y2[ch];
        sub  = 1'b1;
      end
      default: begin
        coef = '0;
        opnd = '0;
      end
    endcase
  end

  iir_mac_unit #(
    .COEFF_WIDTH(COEFF_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (AW)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .en   (state == MAC),
    .clr  (tap == 3'd0),
    .sub  (sub),
    .coef (coef),
    .opnd (opnd),
    .acc  (acc)
  );

endmodule

// File: tb/tb_iir_biquad_scheduler.sv
// Randomized bench for iir_biquad_scheduler.
// Reference: plain-arithmetic biquad equations per channel.
module tb_iir_biquad_scheduler;

  localparam int CW = 18;
  localparam int CS = 14;
  localparam int DW = 16;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic reset;
  logic sample_stb;
  logic [NC*DW-1:0] din;
  logic [CW-1:0] A2, A3, B1, B2, B3;
  logic [NC*DW-1:0] dout;
  logic dout_valid;
  logic busy;
  logic overrun;

  int n_chk = 0;
  int n_err = 0;

  int mx1 [NC];
  int mx2 [NC];
  int my1 [NC];
  int my2 [NC];
  int mout[NC];
  bit movr;

  always #5 clk = ~clk;

  iir_biquad_scheduler #(
    .COEFF_WIDTH(CW),
    .COEFF_SCALE(CS),
    .DATA_WIDTH (DW),
    .NUM_CH     (NC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_stb(sample_stb),
    .din       (din),
    .A2        (A2),
    .A3        (A3),
    .B1        (B1),
    .B2        (B2),
    .B3        (B3),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(
    input string  tag,
    input longint got,
    input longint exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lane(input int c);
    logic signed [DW-1:0] v;
    v = dout[c*DW +: DW];
    return int'(v);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      mx1[c]  = 0;
      mx2[c]  = 0;
      my1[c]  = 0;
      my2[c]  = 0;
      mout[c] = 0;
    end
    movr = 1'b0;
  endtask

  // cf = {b1, b2, b3, a2, a3}
  task automatic model_step(
    input int xs[NC],
    input int cf[5]
  );
    longint acc;
    longint q;
    for (int c = 0; c < NC; c++) begin
      acc = longint'(cf[0]) * xs[c]
          + longint'(cf[1]) * mx1[c]
          + longint'(cf[2]) * mx2[c]
          - longint'(cf[3]) * my1[c]
          - longint'(cf[4]) * my2[c];
      q = acc >>> CS;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      mx2[c]  = mx1[c];
      mx1[c]  = xs[c];
      my2[c]  = my1[c];
      my1[c]  = int'(q);
      mout[c] = int'(q);
    end
  endtask

  task automatic scramble();
    for (int c = 0; c < NC; c++)
      din[c*DW +: DW] = DW'($urandom);
    B1 = CW'($urandom);
    B2 = CW'($urandom);
    B3 = CW'($urandom);
    A2 = CW'($urandom);
    A3 = CW'($urandom);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    sample_stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // called #1 after an edge; returns #1 after the DONE edge
  task automatic run_frame(
    input int xs[NC],
    input int cf[5],
    input int ovr_at
  );
    for (int c = 0; c < NC; c++)
      din[c*DW +: DW] = xs[c][DW-1:0];
    B1 = cf[0][CW-1:0];
    B2 = cf[1][CW-1:0];
    B3 = cf[2][CW-1:0];
    A2 = cf[3][CW-1:0];
    A3 = cf[4][CW-1:0];
    sample_stb = 1'b1;
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
    scramble();
    model_step(xs, cf);
    for (int k = 1; k <= 12; k++) begin
      check("busy_run", busy, 1);
      check("valid_early", dout_valid, 0);
      if (k == ovr_at) begin
        sample_stb = 1'b1;
        movr = 1'b1;
      end
      @(posedge clk);
      #1;
      sample_stb = 1'b0;
    end
    check("valid_done", dout_valid, 1);
    check("busy_done", busy, 0);
    check("overrun", overrun, movr);
    for (int c = 0; c < NC; c++)
      check($sformatf("dout%0d", c), lane(c), mout[c]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("valid_idle", dout_valid, 0);
      check("busy_idle", busy, 0);
      for (int c = 0; c < NC; c++)
        check("dout_hold", lane(c), mout[c]);
    end
  endtask

  task automatic impulse_pair();
    int xs[NC];
    int cf[5];
    cf = '{354, 708, 354, -25283, 10315};
    xs = '{8192, 0};
    run_frame(xs, cf, 0);
    check("imp0_ch0", lane(0), 177);
    check("imp0_ch1", lane(1), 0);
    idle(1);
    xs = '{0, 0};
    run_frame(xs, cf, 0);
    check("imp1_ch0", lane(0), 627);
    check("imp1_ch1", lane(1), 0);
    idle(1);
  endtask

  initial begin
    int xs[NC];
    int cf[5];
    reset      = 1'b1;
    sample_stb = 1'b0;
    din        = '0;
    {A2, A3, B1, B2, B3} = '0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    idle(2);

    // passthrough
    cf = '{16384, 0, 0, 0, 0};
    xs = '{1000, -1234};
    run_frame(xs, cf, 0);
    check("pass_ch0", lane(0), 1000);
    check("pass_ch1", lane(1), -1234);
    idle(3);

    // impulse response
    do_reset();
    impulse_pair();

    // saturation
    do_reset();
    cf = '{32768, 0, 0, 0, 0};
    xs = '{20000, -20000};
    run_frame(xs, cf, 0);
    check("sat_hi", lane(0), 32767);
    check("sat_lo", lane(1), -32768);
    idle(1);
    xs = '{1000, -1000};
    run_frame(xs, cf, 0);
    check("gain2", lane(0), 2000);
    idle(1);

    // overrun
    do_reset();
    cf = '{16384, 0, 0, 0, 0};
    xs = '{321, -4321};
    run_frame(xs, cf, 5);
    check("ovr_ch0", lane(0), 321);
    check("ovr_set", overrun, 1);
    idle(4);
    check("ovr_held", overrun, 1);

    // back-to-back
    do_reset();
    xs = '{77, -88};
    run_frame(xs, cf, 0);
    xs = '{-555, 666};
    run_frame(xs, cf, 0);
    check("b2b_ovr", overrun, 0);
    idle(1);

    // reset mid-frame
    cf = '{354, 708, 354, -25283, 10315};
    xs = '{8192, 8192};
    for (int c = 0; c < NC; c++)
      din[c*DW +: DW] = xs[c][DW-1:0];
    B1 = cf[0][CW-1:0];
    B2 = cf[1][CW-1:0];
    B3 = cf[2][CW-1:0];
    A2 = cf[3][CW-1:0];
    A3 = cf[4][CW-1:0];
    sample_stb = 1'b1;
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check("mid_dout", dout, 0);
    check("mid_busy", busy, 0);
    check("mid_valid", dout_valid, 0);
    idle(13);
    impulse_pair();

    // randomized frames
    do_reset();
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < NC; c++)
        xs[c] = int'($urandom_range(0, 65535)) - 32768;
      for (int i = 0; i < 5; i++) begin
        if (f % 3 == 0)
          cf[i] = int'($urandom_range(0, 262143)) - 131072;
        else
          cf[i] = int'($urandom_range(0, 8191)) - 4096;
      end
      run_frame(xs, cf,
                ($urandom_range(0, 7) == 0) ?
                int'($urandom_range(1, 12)) : 0);
      idle(int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
